uart_cmd_responder: RTL and testbench
=====================================

// Module: uart_cmd_responder
// PURPOSE
//   Command responder on the user side of the uart core. Parses command
//   frames from the receiver outputs (received/rx_byte/recv_error), reads or
//   writes a small internal register file, and returns one reply byte through
//   the transmitter inputs (transmit/tx_byte), paced by is_transmitting.
//   Sits in the core between the uart and on-chip logic that consumes regs.
// PARAMETERS
//   AW       3       register address width; register file holds 2**AW x 8 bit
//   TIMEOUT  50000   inter-byte timeout in clk cycles inside a frame; 0 = off
// PORTS
//   clk              in   1           system clock, rising edge
//   rst              in   1           asynchronous reset, active high
//   received         in   1           1-cycle pulse: rx_byte valid (from uart)
//   rx_byte          in   8           received byte
//   recv_error       in   1           1-cycle pulse: framing error (from uart)
//   is_transmitting  in   1           uart transmitter busy
//   transmit         out  1           1-cycle pulse: send tx_byte (to uart)
//   tx_byte          out  8           reply byte, held stable until next reply
//   regs             out  8*2**AW     register file, reg k at [8k+7:8k]
//   busy             out  1           high in any state other than IDLE
//   err_cnt          out  8           saturating error count (255 sticks)
// BEHAVIOUR
//   Reset (async, rst=1): state IDLE; transmit=0, tx_byte=8'h00, all regs=0,
//     busy=0, err_cnt=0, timeout counter=0. Reset mid-frame/mid-reply aborts
//     with no reply; a transmit pulse never outlives reset.
//   Frames: 'W'(8'h57) ADDR DATA -> write, reply 'K'(8'h4B).
//           'R'(8'h52) ADDR      -> reply regs[ADDR].
//           other opcode byte    -> reply '?'(8'h3F), frame ends.
//     ADDR >= 2**AW: W ignores write, replies '?'; R replies '?'. ADDR bits
//     above AW must be zero to be in range (no aliasing).
//   States: IDLE -(received)-> OPC decode: W/R -> GET_ADDR, else EXEC('?').
//     GET_ADDR -(received)-> R: EXEC; W: GET_DATA. GET_DATA -(received)-> EXEC.
//     EXEC (1 cycle): perform write / latch read data into tx_byte -> TX_START.
//     TX_START: when is_transmitting=0, pulse transmit 1 cycle -> TX_GUARD.
//     TX_GUARD: 2 cycles, is_transmitting ignored -> TX_WAIT.
//     TX_WAIT: when is_transmitting=0 -> IDLE.
//   Latency: last frame byte's received pulse at cycle N -> EXEC at N+1,
//     regs updated visible at N+2, transmit pulse at N+2 if uart idle.
//   tx_byte is updated only in EXEC, so it is stable around the transmit pulse.
//   recv_error: in GET_ADDR/GET_DATA aborts frame to IDLE, no reply; in any
//     state increments err_cnt. received and recv_error same cycle: error wins,
//     byte discarded.
//   Timeout: counter clears on each accepted byte; in GET_ADDR/GET_DATA, after
//     TIMEOUT cycles with no received -> IDLE, no reply, err_cnt+1.
//   Overrun: received while in EXEC/TX_* -> byte dropped, err_cnt+1 (half
//     duplex; no queueing). Multiple error sources same cycle count once.
//   err_cnt saturates at 8'hFF; cleared only by reset.
// TESTING
//   1 W,8'h02,8'hA5 then R,8'h02 -> regs[2]=A5 two cycles after last byte;
//     replies 'K' then 8'hA5, each with exactly one transmit pulse.
//   2 R,8'h09 (AW=3) and W,8'h08,8'h11 -> replies '?' both; regs unchanged.
//   3 opcode 8'h00 -> immediate '?' reply, next byte treated as new opcode.
//   4 W,8'h01 then recv_error pulse -> no transmit, err_cnt=1, state IDLE;
//     subsequent W,8'h01,8'h5A works normally.
//   5 W then silence TIMEOUT+1 cycles -> IDLE, err_cnt+1, no reply; hold
//     is_transmitting=1 at EXEC -> transmit delayed until it drops; byte
//     received during TX_WAIT -> dropped, err_cnt+1.
//   6 assert rst during TX_GUARD -> all outputs reset values immediately;
//     force 300 errors -> err_cnt stays 8'hFF.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// rtl/uart_cmd_responder.sv - byte-command responder: parses W/R frames from the uart receiver,
// accesses a small register file and returns one reply byte through the uart transmitter.
module uart_cmd_responder #(
    parameter int AW      = 3,
    parameter int TIMEOUT = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  received,
    input  logic [7:0]            rx_byte,
    input  logic                  recv_error,
    input  logic                  is_transmitting,
    output logic                  transmit,
    output logic [7:0]            tx_byte,
    output logic [8*(2**AW)-1:0]  regs,
    output logic                  busy,
    output logic [7:0]            err_cnt
);

    localparam int NREG = 2 ** AW;
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [7:0] CH_W  = 8'h57;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_NG = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE, S_GET_ADDR, S_GET_DATA, S_EXEC, S_TX_START, S_TX_GUARD, S_TX_WAIT
    } state_t;

    typedef enum logic [1:0] {OP_W, OP_R, OP_BAD} op_t;

    state_t          state_q, state_d;
    op_t             op_q, op_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            guard_q, guard_d;
    logic [7:0]      regs_q [NREG];
    logic [7:0]      regs_d [NREG];

    logic            addr_ok;
    logic [7:0]      rd_data;
    logic            rx_ok;
    logic            in_frame;
    logic            tmo_fire;
    logic            overrun;
    logic            err_inc;

    // Upper address bits must be zero; out-of-range addresses never alias.
    assign addr_ok  = ((addr_q >> AW) == 8'd0);
    assign rd_data  = regs_q[addr_q[AW-1:0]];
    assign rx_ok    = received & ~recv_error;
    assign in_frame = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA);
    assign tmo_fire = (TIMEOUT != 0) && in_frame && !received && (tmo_q == TMO_LAST);
    assign overrun  = received && (state_q inside {S_EXEC, S_TX_START, S_TX_GUARD, S_TX_WAIT});
    assign err_inc  = recv_error | tmo_fire | overrun;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        tx_byte_d = tx_byte_q;
        tmo_d     = '0;
        guard_d   = guard_q;
        transmit  = 1'b0;
        for (int k = 0; k < NREG; k++) regs_d[k] = regs_q[k];

        case (state_q)
            S_IDLE: begin
                if (rx_ok) begin
                    if (rx_byte == CH_W) begin
                        op_d    = OP_W;
                        state_d = S_GET_ADDR;
                    end else if (rx_byte == CH_R) begin
                        op_d    = OP_R;
                        state_d = S_GET_ADDR;
                    end else begin
                        op_d    = OP_BAD;
                        state_d = S_EXEC;
                    end
                end
            end
            S_GET_ADDR: begin
                if (recv_error || tmo_fire) begin
                    state_d = S_IDLE;
                end else if (rx_ok) begin
                    addr_d  = rx_byte;
                    state_d = (op_q == OP_W) ? S_GET_DATA : S_EXEC;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_GET_DATA: begin
                if (recv_error || tmo_fire) begin
                    state_d = S_IDLE;
                end else if (rx_ok) begin
                    data_d  = rx_byte;
                    state_d = S_EXEC;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_W: begin
                        if (addr_ok) begin
                            regs_d[addr_q[AW-1:0]] = data_q;
                            tx_byte_d = CH_K;
                        end else begin
                            tx_byte_d = CH_NG;
                        end
                    end
                    OP_R:    tx_byte_d = addr_ok ? rd_data : CH_NG;
                    default: tx_byte_d = CH_NG;
                endcase
                state_d = S_TX_START;
            end
            S_TX_START: begin
                if (!is_transmitting) begin
                    transmit = 1'b1;
                    guard_d  = 1'b0;
                    state_d  = S_TX_GUARD;
                end
            end
            // The uart may need a couple of cycles to raise is_transmitting.
            S_TX_GUARD: begin
                guard_d = 1'b1;
                if (guard_q) state_d = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (!is_transmitting) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        err_cnt_d = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_BAD;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            tx_byte_q <= 8'h00;
            err_cnt_q <= 8'h00;
            tmo_q     <= '0;
            guard_q   <= 1'b0;
            for (int k = 0; k < NREG; k++) regs_q[k] <= 8'h00;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            tx_byte_q <= tx_byte_d;
            err_cnt_q <= err_cnt_d;
            tmo_q     <= tmo_d;
            guard_q   <= guard_d;
            for (int k = 0; k < NREG; k++) regs_q[k] <= regs_d[k];
        end
    end

    always_comb begin
        for (int k = 0; k < NREG; k++) regs[8*k +: 8] = regs_q[k];
    end

    assign tx_byte = tx_byte_q;
    assign busy    = (state_q != S_IDLE);
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb/tb_uart_cmd_responder.sv - self-checking bench for uart_cmd_responder.
module tb_uart_cmd_responder;

    localparam int AW      = 3;
    localparam int TIMEOUT = 20;
    localparam int NV      = 13;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        received = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        recv_error = 1'b0;
    logic        is_transmitting = 1'b0;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic [63:0] regs;
    logic        busy;
    logic [7:0]  err_cnt;

    uart_cmd_responder #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .received(received), .rx_byte(rx_byte),
        .recv_error(recv_error), .is_transmitting(is_transmitting),
        .transmit(transmit), .tx_byte(tx_byte), .regs(regs), .busy(busy),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] op;
        logic [7:0] addr;
        logic [7:0] data;
        int         nb;
        logic [7:0] reply;
    } vec_t;

    vec_t        vecs [NV];
    logic [7:0]  mreg [8];
    logic [7:0]  sb [$];
    logic [7:0]  sb_exp;
    int          checks = 0;
    int          errors = 0;
    int          tx_count = 0;
    int          exp_err = 0;
    int          t0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_flat();
        logic [63:0] f;
        for (int k = 0; k < 8; k++) f[8*k +: 8] = mreg[k];
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        received = 1'b1;
        rx_byte  = b;
        tick();
        received = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200 && busy; k++) tick();
        check("idle_within_budget", {63'd0, busy}, 64'd0);
    endtask

    task automatic wait_tx();
        for (int k = 0; k < 50 && !transmit; k++) tick();
        check("transmit_within_budget", {63'd0, transmit}, 64'd1);
    endtask

    // Scoreboard: every transmit pulse must match the oldest expected reply.
    always @(negedge clk) begin
        if (!rst && transmit) begin
            tx_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_transmit: got tx_byte %0h expected no reply", tx_byte);
            end else begin
                sb_exp = sb.pop_front();
                check("reply_byte", {56'd0, tx_byte}, {56'd0, sb_exp});
            end
        end
    end

    initial begin
        vecs[0]  = '{8'h57, 8'h02, 8'hA5, 3, 8'h4B};
        vecs[1]  = '{8'h52, 8'h02, 8'h00, 2, 8'hA5};
        vecs[2]  = '{8'h52, 8'h09, 8'h00, 2, 8'h3F};
        vecs[3]  = '{8'h57, 8'h08, 8'h11, 3, 8'h3F};
        vecs[4]  = '{8'h52, 8'h08, 8'h00, 2, 8'h3F};
        vecs[5]  = '{8'h57, 8'h07, 8'h3C, 3, 8'h4B};
        vecs[6]  = '{8'h52, 8'h07, 8'h00, 2, 8'h3C};
        vecs[7]  = '{8'h00, 8'h00, 8'h00, 1, 8'h3F};
        vecs[8]  = '{8'h52, 8'h07, 8'h00, 2, 8'h3C};
        vecs[9]  = '{8'h57, 8'h00, 8'hFF, 3, 8'h4B};
        vecs[10] = '{8'h52, 8'h00, 8'h00, 2, 8'hFF};
        vecs[11] = '{8'h57, 8'h82, 8'h66, 3, 8'h3F};
        vecs[12] = '{8'h52, 8'h02, 8'h00, 2, 8'hA5};
        for (int k = 0; k < 8; k++) mreg[k] = 8'h00;

        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        tick();

        check("reset_transmit", {63'd0, transmit}, 64'd0);
        check("reset_tx_byte", {56'd0, tx_byte}, 64'd0);
        check("reset_regs", regs, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_err_cnt", {56'd0, err_cnt}, 64'd0);

        for (int i = 0; i < NV; i++) begin
            t0 = tx_count;
            sb.push_back(vecs[i].reply);
            send(vecs[i].op);
            if (vecs[i].nb > 1) send(vecs[i].addr);
            if (vecs[i].nb > 2) send(vecs[i].data);
            wait_idle();
            if (vecs[i].op == 8'h57 && vecs[i].nb == 3 && vecs[i].addr < 8)
                mreg[vecs[i].addr[2:0]] = vecs[i].data;
            check("vec_tx_pulses", 64'(tx_count - t0), 64'd1);
            check("vec_regs", regs, model_flat());
            check("vec_err_cnt", {56'd0, err_cnt}, 64'd0);
        end

        // Write latency: EXEC one cycle after the last byte, regs and pulse the cycle after.
        sb.push_back(8'h4B);
        send(8'h57);
        send(8'h03);
        send(8'h77);
        check("lat_exec_busy", {63'd0, busy}, 64'd1);
        check("lat_exec_no_tx", {63'd0, transmit}, 64'd0);
        check("lat_exec_reg_old", {56'd0, regs[31:24]}, 64'd0);
        tick();
        check("lat_reg_new", {56'd0, regs[31:24]}, 64'h77);
        check("lat_tx_pulse", {63'd0, transmit}, 64'd1);
        check("lat_tx_byte", {56'd0, tx_byte}, 64'h4B);
        wait_idle();
        mreg[3] = 8'h77;

        // Framing error aborts mid-frame; simultaneous byte+error discards the byte.
        t0 = tx_count;
        send(8'h57);
        send(8'h01);
        recv_error = 1'b1;
        tick();
        recv_error = 1'b0;
        exp_err = 1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_err_cnt", {56'd0, err_cnt}, 64'(exp_err));
        received = 1'b1;
        rx_byte = 8'h57;
        recv_error = 1'b1;
        tick();
        received = 1'b0;
        recv_error = 1'b0;
        exp_err = 2;
        check("err_wins_busy", {63'd0, busy}, 64'd0);
        check("err_wins_err_cnt", {56'd0, err_cnt}, 64'(exp_err));
        repeat (5) tick();
        check("abort_no_reply", 64'(tx_count - t0), 64'd0);
        sb.push_back(8'h4B);
        send(8'h57);
        send(8'h01);
        send(8'h5A);
        wait_idle();
        mreg[1] = 8'h5A;
        check("after_abort_regs", regs, model_flat());

        // Inter-byte timeout.
        t0 = tx_count;
        send(8'h57);
        repeat (TIMEOUT - 1) tick();
        check("tmo_still_busy", {63'd0, busy}, 64'd1);
        tick();
        exp_err = 3;
        check("tmo_idle", {63'd0, busy}, 64'd0);
        check("tmo_err_cnt", {56'd0, err_cnt}, 64'(exp_err));
        check("tmo_no_reply", 64'(tx_count - t0), 64'd0);

        // Transmitter busy at EXEC delays the pulse.
        t0 = tx_count;
        is_transmitting = 1'b1;
        sb.push_back(8'hA5);
        send(8'h52);
        send(8'h02);
        repeat (5) tick();
        check("hold_busy", {63'd0, busy}, 64'd1);
        check("hold_no_tx", 64'(tx_count - t0), 64'd0);
        is_transmitting = 1'b0;
        wait_idle();
        check("hold_one_tx", 64'(tx_count - t0), 64'd1);

        // Byte arriving during TX_WAIT is dropped as an overrun.
        t0 = tx_count;
        sb.push_back(8'h3C);
        send(8'h52);
        send(8'h07);
        wait_tx();
        is_transmitting = 1'b1;
        tick();
        tick();
        tick();
        send(8'h52);
        exp_err = 4;
        check("overrun_err_cnt", {56'd0, err_cnt}, 64'(exp_err));
        check("overrun_busy", {63'd0, busy}, 64'd1);
        is_transmitting = 1'b0;
        wait_idle();
        repeat (5) tick();
        check("overrun_idle", {63'd0, busy}, 64'd0);
        check("overrun_one_tx", 64'(tx_count - t0), 64'd1);

        // Asynchronous reset in TX_GUARD.
        sb.push_back(8'hA5);
        send(8'h52);
        send(8'h02);
        wait_tx();
        tick();
        #2 rst = 1'b1;
        #1;
        check("rst_transmit", {63'd0, transmit}, 64'd0);
        check("rst_tx_byte", {56'd0, tx_byte}, 64'd0);
        check("rst_regs", regs, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_err_cnt", {56'd0, err_cnt}, 64'd0);
        #2 rst = 1'b0;
        tick();

        // Error counter saturation.
        recv_error = 1'b1;
        repeat (254) tick();
        check("err_cnt_254", {56'd0, err_cnt}, 64'hFE);
        repeat (46) tick();
        recv_error = 1'b0;
        check("err_cnt_sat", {56'd0, err_cnt}, 64'hFF);
        tick();
        check("err_cnt_stays", {56'd0, err_cnt}, 64'hFF);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
